// File: rtl/dsp_brr_encoder_if.sv
// Sample stream and ARAM write bus of dsp_brr_encoder.
// Handshake: a sample transfers on a rising clock edge where sample_valid and
// sample_ready are both 1; sample_in and sample_last are meaningful only while
// sample_valid is 1, and the source holds them until the transfer happens.
// The RAM side has no ready: every cycle with ram_write_request=1 writes
// ram_write_data to ram_address.
interface dsp_brr_encoder_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_last;
    logic        sample_ready;
    logic [15:0] ram_address;
    logic [7:0]  ram_write_data;
    logic        ram_write_request;

    // PCM source / ARAM side
    modport master (
        output sample_in, sample_valid, sample_last,
        input  sample_ready, ram_address, ram_write_data, ram_write_request
    );

    // encoder side
    modport slave (
        input  sample_in, sample_valid, sample_last,
        output sample_ready, ram_address, ram_write_data, ram_write_request
    );
endinterface

// File: rtl/dsp_brr_encoder.sv
// Streaming BRR encoder: collects 16 signed PCM samples, picks a shift (and
// optionally a filter), then writes a 9-byte block (header + 8 nibble-pair
// bytes) to ARAM, one byte per cycle.
// Optional feature macro: BRR_ENC_FILTER1_EN enables filter-1 (15/16
// predictor) selection and closed-loop quantisation; without it every block
// uses filter 0.
module dsp_brr_encoder #(
    parameter int MAX_SHIFT   = 12,
    parameter int BLOCK_SAMPS = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       start_address,
    input  logic              loop_enable,
    dsp_brr_encoder_if.slave  bus,
    output logic              block_done,
    output logic              reached_end,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_COLLECT      = 4'd1,
        ST_PAD          = 4'd2,
        ST_ANALYZE      = 4'd3,
        ST_WRITE_HEADER = 4'd4,
        ST_WRITE_DATA   = 4'd5,
        ST_END          = 4'd6
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(BLOCK_SAMPS - 1);

    state_t state_q, state_d;

    logic [15:0]        ptr;
    logic               loop_en;
    logic               end_flag;
    logic [3:0]         idx;
    logic [2:0]         k;
    logic signed [15:0] buffer [0:BLOCK_SAMPS-1];
    logic [3:0]         shift0_run;
    logic [3:0]         blk_shift;
    logic [1:0]         blk_filter;

    logic               xfer;
    logic               store_en;
    logic signed [15:0] store_val;
    logic signed [15:0] x_even, x_odd;
    logic [3:0]         q_even, q_odd;

    // Smallest shift in 0..MAX_SHIFT that brings r into the 4-bit signed range.
    function automatic logic [3:0] shift_of(input logic signed [16:0] r);
        logic [3:0]         res;
        logic signed [16:0] t;
        res = 4'(MAX_SHIFT);
        for (int s = MAX_SHIFT; s >= 0; s--) begin
            t = r >>> s;
            if (t >= -17'sd8 && t <= 17'sd7) res = 4'(s);
        end
        return res;
    endfunction

    function automatic logic [3:0] max4(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? a : b;
    endfunction

`ifdef BRR_ENC_FILTER1_EN
    logic [3:0]         shift1_run;
    logic signed [15:0] raw_prev;
    logic signed [15:0] recon_prev;
    logic               first_blk;
    logic signed [16:0] pred_raw, pred_even, pred_odd;
    logic signed [15:0] recon_mid, recon_next;

    // p*15/16 with the division truncating toward zero.
    function automatic logic signed [16:0] pred_of(input logic signed [15:0] p);
        logic signed [20:0] m;
        m = {{5{p[15]}}, p} * 21'sd15;
        if (m < 0) m = m + 21'sd15;
        return 17'(m >>> 4);
    endfunction

    // Residual against the prediction, shifted and clamped to a nibble.
    function automatic logic [3:0] quant(input logic signed [15:0] x,
                                         input logic signed [16:0] pred,
                                         input logic [3:0] sh);
        logic signed [16:0] d;
        d = $signed({x[15], x}) - pred;
        d = d >>> sh;
        if (d > 17'sd7)  return 4'h7;
        if (d < -17'sd8) return 4'h8;
        return d[3:0];
    endfunction

    // Decoder-side reconstruction of one sample, wrapped to 16 bits.
    function automatic logic signed [15:0] recon(input logic [3:0] q,
                                                 input logic signed [16:0] pred,
                                                 input logic [3:0] sh);
        logic signed [16:0] v;
        v = $signed({{13{q[3]}}, q}) <<< sh;
        v = v + pred;
        return v[15:0];
    endfunction

    assign pred_raw = pred_of(raw_prev);

    // Two chained closed-loop quantise/reconstruct steps per data byte.
    always_comb begin
        pred_even  = blk_filter[0] ? pred_of(recon_prev) : 17'sd0;
        q_even     = quant(x_even, pred_even, blk_shift);
        recon_mid  = recon(q_even, pred_even, blk_shift);
        pred_odd   = blk_filter[0] ? pred_of(recon_mid) : 17'sd0;
        q_odd      = quant(x_odd, pred_odd, blk_shift);
        recon_next = recon(q_odd, pred_odd, blk_shift);
    end
`else
    assign blk_filter = 2'b00;

    // Filter 0: floor shift of the raw sample always fits the nibble.
    always_comb begin
        q_even = 4'(x_even >>> blk_shift);
        q_odd  = 4'(x_odd >>> blk_shift);
    end
`endif

    assign xfer      = (state_q == ST_COLLECT) && bus.sample_valid;
    assign store_en  = xfer || (state_q == ST_PAD);
    assign store_val = (state_q == ST_COLLECT) ? bus.sample_in : 16'sd0;
    assign x_even    = buffer[{k, 1'b0}];
    assign x_odd     = buffer[{k, 1'b1}];
    assign state     = state_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_END: if (start) state_d = ST_COLLECT;
            ST_COLLECT: begin
                if (xfer && (bus.sample_last || idx == LAST_IDX))
                    state_d = (idx == LAST_IDX) ? ST_ANALYZE : ST_PAD;
            end
            ST_PAD:          if (idx == LAST_IDX) state_d = ST_ANALYZE;
            ST_ANALYZE:      state_d = ST_WRITE_HEADER;
            ST_WRITE_HEADER: state_d = ST_WRITE_DATA;
            ST_WRITE_DATA:   if (k == 3'd7) state_d = end_flag ? ST_END : ST_COLLECT;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.sample_ready      = 1'b0;
        bus.ram_write_request = 1'b0;
        bus.ram_address       = 16'd0;
        bus.ram_write_data    = 8'd0;
        block_done            = 1'b0;
        case (state_q)
            ST_COLLECT: bus.sample_ready = 1'b1;
            ST_WRITE_HEADER: begin
                bus.ram_write_request = 1'b1;
                bus.ram_address       = ptr;
                bus.ram_write_data    = {blk_shift, blk_filter, end_flag & loop_en, end_flag};
            end
            ST_WRITE_DATA: begin
                bus.ram_write_request = 1'b1;
                bus.ram_address       = ptr + 16'd1 + {13'd0, k};
                bus.ram_write_data    = {q_even, q_odd};
                block_done            = (k == 3'd7);
            end
            default: ;
        endcase
    end

    // Block datapath: sample buffer, running shift, write pointer, flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr         <= 16'd0;
            loop_en     <= 1'b0;
            end_flag    <= 1'b0;
            idx         <= 4'd0;
            k           <= 3'd0;
            shift0_run  <= 4'd0;
            blk_shift   <= 4'd0;
            reached_end <= 1'b0;
            for (int i = 0; i < BLOCK_SAMPS; i++) buffer[i] <= 16'sd0;
`ifdef BRR_ENC_FILTER1_EN
            shift1_run  <= 4'd0;
            raw_prev    <= 16'sd0;
            recon_prev  <= 16'sd0;
            first_blk   <= 1'b1;
            blk_filter  <= 2'b00;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_END: begin
                    if (start) begin
                        ptr         <= start_address;
                        loop_en     <= loop_enable;
                        end_flag    <= 1'b0;
                        idx         <= 4'd0;
                        shift0_run  <= 4'd0;
                        reached_end <= 1'b0;
`ifdef BRR_ENC_FILTER1_EN
                        shift1_run  <= 4'd0;
                        raw_prev    <= 16'sd0;
                        recon_prev  <= 16'sd0;
                        first_blk   <= 1'b1;
`endif
                    end
                end
                ST_ANALYZE: begin
`ifdef BRR_ENC_FILTER1_EN
                    if (!first_blk && shift1_run < shift0_run) begin
                        blk_filter <= 2'b01;
                        blk_shift  <= shift1_run;
                    end else begin
                        blk_filter <= 2'b00;
                        blk_shift  <= shift0_run;
                    end
`else
                    blk_shift <= shift0_run;
`endif
                end
                ST_WRITE_HEADER: k <= 3'd0;
                ST_WRITE_DATA: begin
                    k <= k + 3'd1;
`ifdef BRR_ENC_FILTER1_EN
                    recon_prev <= recon_next;
`endif
                    if (k == 3'd7) begin
                        ptr        <= ptr + 16'd9;
                        idx        <= 4'd0;
                        shift0_run <= 4'd0;
`ifdef BRR_ENC_FILTER1_EN
                        shift1_run <= 4'd0;
                        first_blk  <= 1'b0;
`endif
                        if (end_flag) reached_end <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (store_en) begin
                buffer[idx] <= store_val;
                idx         <= idx + 4'd1;
                shift0_run  <= max4(shift0_run, shift_of({store_val[15], store_val}));
`ifdef BRR_ENC_FILTER1_EN
                shift1_run  <= max4(shift1_run,
                                    shift_of($signed({store_val[15], store_val}) - pred_raw));
                raw_prev    <= store_val;
`endif
                if (xfer && bus.sample_last) end_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsp_brr_encoder.sv
// Bench for dsp_brr_encoder: table of single-block streams, hand-written
// latency / padding / reset sequences, and a scoreboard of expected ARAM
// writes {address, data} checked as the encoder emits them.
module tb_dsp_brr_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] start_address;
    logic        loop_enable;
    logic        block_done;
    logic        reached_end;
    logic [3:0]  state;

    dsp_brr_encoder_if bus();

    dsp_brr_encoder dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .start_address (start_address),
        .loop_enable   (loop_enable),
        .bus           (bus),
        .block_done    (block_done),
        .reached_end   (reached_end),
        .state         (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_w;
    logic        prev_req = 1'b0;
    int          burst_cyc = 0;
    int          done_cyc = 0;
    int          n_done = 0;
    int          pad_cnt = 0;
    int          accept_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus.ram_write_request) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%h data 0x%h, expected no write",
                         bus.ram_address, bus.ram_write_data);
            end else begin
                exp_w = exp_q.pop_front();
                check("ram_write", {8'd0, bus.ram_address, bus.ram_write_data}, {8'd0, exp_w});
            end
            if (!prev_req) burst_cyc = cyc;
        end
        prev_req = bus.ram_write_request;
        if (block_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (state == 4'd2) pad_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic start_stream(input logic [15:0] addr, input logic lp);
        start = 1'b1;
        start_address = addr;
        loop_enable = lp;
        @(posedge clock);
        #1;
        start = 1'b0;
        start_address = 16'($urandom);
        loop_enable = ~lp;
    endtask

    task automatic send_sample(input logic [15:0] v, input logic last);
        int budget = 200;
        bus.sample_in = v;
        bus.sample_last = last;
        bus.sample_valid = 1'b1;
        while (budget > 0) begin
            @(negedge clock);
            if (bus.sample_ready) break;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: sample_ready 0, expected 1");
        end else begin
            accept_cyc = cyc;
        end
        @(posedge clock);
        #1;
        bus.sample_valid = 1'b0;
        bus.sample_last = 1'b0;
        bus.sample_in = 16'($urandom);
    endtask

    task automatic push_block(input logic [15:0] addr, input logic [7:0] hdr, input logic [63:0] by);
        exp_q.push_back({addr, hdr});
        for (int k = 0; k < 8; k++)
            exp_q.push_back({16'(addr + 16'(k + 1)), by[63 - 8 * k -: 8]});
    endtask

    task automatic wait_end(input string name);
        int budget = 100;
        while (!reached_end && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (!reached_end) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: reached_end 0, expected 1", name);
        end
    endtask

    task automatic wait_done(input int target);
        int budget = 200;
        while (n_done < target && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (n_done < target) begin
            checks++;
            errors++;
            $display("FAIL block_done_timeout: got %0d blocks, expected %0d", n_done, target);
        end
    endtask

    // Independent filter-0 reference for random blocks.
    function automatic logic [3:0] ref_shift(input logic signed [15:0] r);
        logic signed [15:0] t;
        for (int s = 0; s <= 12; s++) begin
            t = r >>> s;
            if (t >= -8 && t <= 7) return 4'(s);
        end
        return 4'd12;
    endfunction

    task automatic random_stream();
        logic [15:0]        addr;
        logic signed [15:0] s [16];
        logic [3:0]         sh;
        logic [63:0]        by;
        addr = 16'($urandom);
        start_stream(addr, 1'b1);
        for (int b = 0; b < 3; b++) begin
            sh = 4'd0;
            for (int i = 0; i < 16; i++) begin
                s[i] = $signed(16'($urandom)) >>> $urandom_range(0, 15);
                if (ref_shift(s[i]) > sh) sh = ref_shift(s[i]);
            end
            for (int k = 0; k < 8; k++)
                by[63 - 8 * k -: 8] = {4'(s[2 * k] >>> sh), 4'(s[2 * k + 1] >>> sh)};
            push_block(16'(addr + 16'(9 * b)), {sh, 2'b00, (b == 2), (b == 2)}, by);
            for (int i = 0; i < 16; i++) send_sample(s[i], (b == 2) && (i == 15));
        end
        wait_end("random");
        check("random_state_end", {28'd0, state}, 32'd6);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] addr;
        logic        lp;
        logic [15:0] s0;
        logic [15:0] s_even;
        logic [15:0] s_odd;
        logic [7:0]  hdr;
        logic [63:0] bytes;
    } vec_t;

    vec_t vecs [7];

    // ---------------- main sequence ----------------
    initial begin
        int t_acc;
        int ready_hits;
        int done_base;
        int pad_base;
        logic [15:0] v;

        vecs[0] = '{16'h0200, 1'b0, 16'h0000, 16'h0000, 16'h0000, 8'h01, 64'h0000_0000_0000_0000};
        vecs[1] = '{16'h1000, 1'b0, 16'h0007, 16'h0007, 16'hFFF8, 8'h01, 64'h7878_7878_7878_7878};
        vecs[2] = '{16'h2000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 8'h03, 64'h0000_0000_0000_0000};
        vecs[3] = '{16'hFFFA, 1'b0, 16'd100,  16'd100,  16'd100,  8'h41, 64'h6666_6666_6666_6666};
        vecs[4] = '{16'h0800, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{16'h0A00, 1'b0, 16'h8000, 16'h0000, 16'h0000, 8'hC1, 64'h8000_0000_0000_0000};
        vecs[6] = '{16'h3456, 1'b0, 16'd1000, 16'hFED4, 16'd37,   8'h71, 64'h70D0_D0D0_D0D0_D0D0};

        reset = 1'b1;
        start = 1'b0;
        start_address = 16'h0000;
        loop_enable = 1'b0;
        bus.sample_in = 16'h0000;
        bus.sample_valid = 1'b0;
        bus.sample_last = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_request", {31'd0, bus.ram_write_request}, 32'd0);
        check("reset_ready", {31'd0, bus.sample_ready}, 32'd0);
        check("reset_block_done", {31'd0, block_done}, 32'd0);
        check("reset_reached_end", {31'd0, reached_end}, 32'd0);
        check("reset_address", {16'd0, bus.ram_address}, 32'd0);
        check("reset_data", {24'd0, bus.ram_write_data}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // single-block streams, last on 16th sample
        for (int n = 0; n < 7; n++) begin
            start_stream(vecs[n].addr, vecs[n].lp);
            push_block(vecs[n].addr, vecs[n].hdr, vecs[n].bytes);
            for (int i = 0; i < 16; i++) begin
                v = (i == 0) ? vecs[n].s0 : ((i % 2 == 1) ? vecs[n].s_odd : vecs[n].s_even);
                send_sample(v, i == 15);
            end
            wait_end("table");
            check("table_state_end", {28'd0, state}, 32'd6);
            check("table_queue_empty", exp_q.size(), 32'd0);
        end

        // full block without last: latency, return to COLLECT, pointer advance
        start_stream(16'h0300, 1'b0);
        push_block(16'h0300, 8'hC0, 64'h7000_0000_0000_0000);
        done_base = n_done;
        send_sample(16'h7FFF, 1'b0);
        for (int i = 1; i < 4; i++) send_sample(16'h0000, 1'b0);
        start_stream(16'h5555, 1'b1);
        for (int i = 4; i < 16; i++) send_sample(16'h0000, 1'b0);
        t_acc = accept_cyc;
        ready_hits = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (bus.sample_ready) ready_hits++;
        end
        check("ready_low_during_write", ready_hits, 32'd0);
        @(negedge clock);
        check("ready_back_T11", {31'd0, bus.sample_ready}, 32'd1);
        check("state_collect_T11", {28'd0, state}, 32'd1);
        check("header_latency", burst_cyc - t_acc, 32'd2);
        check("block_done_latency", done_cyc - t_acc, 32'd10);
        check("block_done_count", n_done - done_base, 32'd1);
        @(posedge clock);
        #1;
        push_block(16'h0309, 8'h01, 64'h0);
        for (int i = 0; i < 16; i++) send_sample(16'h0000, i == 15);
        wait_end("second_block");
        check("second_block_state", {28'd0, state}, 32'd6);

        // short final block: zero padding, valid held high outside COLLECT
        start_stream(16'h0500, 1'b1);
        push_block(16'h0500, 8'h43, 64'h6930_F000_0000_0000);
        pad_base = pad_cnt;
        send_sample(16'd100, 1'b0);
        send_sample(16'hFF9C, 1'b0);
        send_sample(16'd50, 1'b0);
        send_sample(16'd7, 1'b0);
        send_sample(16'hFFF8, 1'b1);
        bus.sample_in = 16'h7FFF;
        bus.sample_last = 1'b1;
        bus.sample_valid = 1'b1;
        wait_end("pad");
        check("pad_cycles", pad_cnt - pad_base, 32'd11);
        check("pad_state_end", {28'd0, state}, 32'd6);
        @(posedge clock);
        #1;
        bus.sample_valid = 1'b0;
        bus.sample_last = 1'b0;
        check("pad_queue_empty", exp_q.size(), 32'd0);

        // reset during WRITE_DATA k=3, with start asserted alongside
        start_stream(16'h0600, 1'b0);
        exp_q.push_back({16'h0600, 8'h40});
        for (int k = 1; k <= 4; k++) exp_q.push_back({16'(16'h0600 + 16'(k)), 8'h66});
        for (int i = 0; i < 16; i++) send_sample(16'd100, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        start = 1'b1;
        start_address = 16'h7777;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("rst_mid_request", {31'd0, bus.ram_write_request}, 32'd0);
        check("rst_mid_state", {28'd0, state}, 32'd0);
        check("rst_mid_ready", {31'd0, bus.sample_ready}, 32'd0);
        check("rst_mid_block_done", {31'd0, block_done}, 32'd0);
        check("rst_mid_address", {16'd0, bus.ram_address}, 32'd0);
        check("rst_mid_data", {24'd0, bus.ram_write_data}, 32'd0);
        check("rst_mid_queue", exp_q.size(), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        start_stream(16'h0700, 1'b0);
        push_block(16'h0700, 8'h01, 64'h0);
        for (int i = 0; i < 16; i++) send_sample(16'h0000, i == 15);
        wait_end("after_reset");
        check("after_reset_state", {28'd0, state}, 32'd6);

`ifdef BRR_ENC_FILTER1_EN
        // constant 4096: filter 0 forced first, filter 1 wins afterwards
        start_stream(16'h0000, 1'b0);
        push_block(16'h0000, 8'hA0, 64'h4444_4444_4444_4444);
        push_block(16'h0009, 8'h64, 64'h4444_4444_4444_4444);
        done_base = n_done;
        for (int i = 0; i < 32; i++) send_sample(16'd4096, 1'b0);
        wait_done(done_base + 2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("filter1_state_idle", {28'd0, state}, 32'd0);
`else
        for (int r = 0; r < 4; r++) random_stream();
`endif

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
